// File: rtl/dram_timed_bfm_if.sv
// dram_timed_bfm_if: command/response bundle for the timing-aware DRAM model.
//   master: cmd_valid, cmd, bankid, rowid, colid, din driven; cmd_ready, dout,
//           dout_valid, cmd_err, bank_busy, err_cnt observed.
//   slave : the DRAM model side (directions reversed).
interface dram_timed_bfm_if #(
    parameter int unsigned NUM_OF_BANKS = 8,
    parameter int unsigned NUM_OF_ROWS  = 128,
    parameter int unsigned NUM_OF_COLS  = 8,
    parameter int unsigned DATA_WIDTH   = 8
);
    localparam int unsigned BANK_W = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1;
    localparam int unsigned ROW_W  = (NUM_OF_ROWS  > 1) ? $clog2(NUM_OF_ROWS)  : 1;
    localparam int unsigned COL_W  = (NUM_OF_COLS  > 1) ? $clog2(NUM_OF_COLS)  : 1;

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [1:0]              cmd;
    logic [BANK_W-1:0]       bankid;
    logic [ROW_W-1:0]        rowid;
    logic [COL_W-1:0]        colid;
    logic [DATA_WIDTH-1:0]   din;
    logic [DATA_WIDTH-1:0]   dout;
    logic                    dout_valid;
    logic                    cmd_err;
    logic [NUM_OF_BANKS-1:0] bank_busy;
    logic [7:0]              err_cnt;

    modport master (
        output cmd_valid, cmd, bankid, rowid, colid, din,
        input  cmd_ready, dout, dout_valid, cmd_err, bank_busy, err_cnt
    );

    modport slave (
        input  cmd_valid, cmd, bankid, rowid, colid, din,
        output cmd_ready, dout, dout_valid, cmd_err, bank_busy, err_cnt
    );
endinterface

// File: rtl/dram_timed_bfm.sv
// dram_timed_bfm: timing-aware DRAM bus-functional model.
//   Per-bank open-row FSM enforcing tRCD/tRP, CAS-latency read pipeline and
//   one-cycle cmd_err pulse for illegal commands.
// Ports:
//   clk   - clock
//   rst_b - asynchronous active-low reset
//   bus   - dram_timed_bfm_if.slave (command, write data, read data, status)
// Optional feature: define DRAM_ERR_CNT_EN to get a saturating 8-bit error
//   counter on bus.err_cnt; otherwise err_cnt is tied to zero.
module dram_timed_bfm #(
    parameter int unsigned NUM_OF_BANKS = 8,
    parameter int unsigned NUM_OF_ROWS  = 128,
    parameter int unsigned NUM_OF_COLS  = 8,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned T_RCD        = 3,
    parameter int unsigned T_RP         = 2,
    parameter int unsigned T_CL         = 2
) (
    input logic             clk,
    input logic             rst_b,
    dram_timed_bfm_if.slave bus
);
    localparam int unsigned BANK_W    = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1;
    localparam int unsigned ROW_W     = (NUM_OF_ROWS  > 1) ? $clog2(NUM_OF_ROWS)  : 1;
    localparam int unsigned T_MAX     = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int unsigned TMR_W     = $clog2(T_MAX + 1);
    localparam int unsigned MEM_DEPTH = NUM_OF_BANKS * NUM_OF_ROWS * NUM_OF_COLS;
    localparam int unsigned ADDR_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] CMD_ACT = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_PRE = 2'b11;

    typedef enum logic [1:0] {
        BANK_IDLE,
        BANK_ACTIVATING,
        BANK_ACTIVE,
        BANK_PRECHARGING
    } bank_state_e;

    bank_state_e             state_q    [NUM_OF_BANKS];
    bank_state_e             state_d    [NUM_OF_BANKS];
    bank_state_e             eff_c      [NUM_OF_BANKS];
    logic [TMR_W-1:0]        timer_q    [NUM_OF_BANKS];
    logic [TMR_W-1:0]        timer_d    [NUM_OF_BANKS];
    logic [ROW_W-1:0]        open_row_q [NUM_OF_BANKS];
    logic [ROW_W-1:0]        open_row_d [NUM_OF_BANKS];
    logic [NUM_OF_BANKS-1:0] busy_q;
    logic                    ready_q;
    logic                    err_q;
    logic                    accept_c;
    logic                    illegal_c;
    logic                    rd_ok_c;
    logic                    wr_ok_c;
    logic [ADDR_W-1:0]       addr_c;
    logic [DATA_WIDTH-1:0]   rd_data_c;
    logic                    tail_v;
    logic [DATA_WIDTH-1:0]   tail_d;
    logic [DATA_WIDTH-1:0]   dout_q;
    logic                    dout_valid_q;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    assign accept_c  = bus.cmd_valid & ready_q;
    assign addr_c    = ADDR_W'((int'(bus.bankid) * int'(NUM_OF_ROWS) + int'(bus.rowid))
                               * int'(NUM_OF_COLS) + int'(bus.colid));
    assign rd_data_c = mem[addr_c];

    // A bank whose timer has reached 1 already behaves as its destination state,
    // so the command is legal exactly T_RCD / T_RP cycles after the accept.
    always_comb begin
        for (int i = 0; i < NUM_OF_BANKS; i++) begin
            eff_c[i] = state_q[i];
            if (timer_q[i] == TMR_W'(1)) begin
                if (state_q[i] == BANK_ACTIVATING)  eff_c[i] = BANK_ACTIVE;
                if (state_q[i] == BANK_PRECHARGING) eff_c[i] = BANK_IDLE;
            end
        end
    end

    // Per-bank next state, command legality and array access strobes.
    always_comb begin
        illegal_c = 1'b0;
        rd_ok_c   = 1'b0;
        wr_ok_c   = 1'b0;
        for (int i = 0; i < NUM_OF_BANKS; i++) begin
            state_d[i]    = eff_c[i];
            timer_d[i]    = timer_q[i];
            open_row_d[i] = open_row_q[i];
            if (eff_c[i] == BANK_ACTIVATING || eff_c[i] == BANK_PRECHARGING) begin
                timer_d[i] = timer_q[i] - TMR_W'(1);
            end
            if (accept_c && bus.bankid == BANK_W'(i)) begin
                case (bus.cmd)
                    CMD_ACT: begin
                        if (eff_c[i] == BANK_IDLE) begin
                            state_d[i]    = BANK_ACTIVATING;
                            timer_d[i]    = TMR_W'(T_RCD);
                            open_row_d[i] = bus.rowid;
                        end else begin
                            illegal_c = 1'b1;
                        end
                    end
                    CMD_RD, CMD_WR: begin
                        if (eff_c[i] == BANK_ACTIVE && bus.rowid == open_row_q[i]) begin
                            rd_ok_c = (bus.cmd == CMD_RD);
                            wr_ok_c = (bus.cmd == CMD_WR);
                        end else begin
                            illegal_c = 1'b1;
                        end
                    end
                    CMD_PRE: begin
                        if (eff_c[i] == BANK_ACTIVE) begin
                            state_d[i] = BANK_PRECHARGING;
                            timer_d[i] = TMR_W'(T_RP);
                        end else if (eff_c[i] != BANK_IDLE) begin
                            illegal_c = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Bank state, handshake and status registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < NUM_OF_BANKS; i++) begin
                state_q[i]    <= BANK_IDLE;
                timer_q[i]    <= '0;
                open_row_q[i] <= '0;
            end
            busy_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_OF_BANKS; i++) begin
                state_q[i]    <= state_d[i];
                timer_q[i]    <= timer_d[i];
                open_row_q[i] <= open_row_d[i];
                busy_q[i]     <= (state_d[i] == BANK_ACTIVATING) ||
                                 (state_d[i] == BANK_PRECHARGING);
            end
            ready_q <= 1'b1;
            err_q   <= illegal_c;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_ok_c) mem[addr_c] <= bus.din;
    end

    // CAS-latency pipeline: T_CL-1 internal stages feed the output register.
    generate
        if (T_CL == 1) begin : g_no_pipe
            assign tail_v = rd_ok_c;
            assign tail_d = rd_data_c;
        end else begin : g_pipe
            logic [T_CL-2:0]       v_q;
            logic [DATA_WIDTH-1:0] d_q [T_CL-1];

            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    v_q <= '0;
                end else begin
                    v_q[0] <= rd_ok_c;
                    for (int k = 1; k < int'(T_CL) - 1; k++) v_q[k] <= v_q[k-1];
                end
            end

            always_ff @(posedge clk) begin
                d_q[0] <= rd_data_c;
                for (int k = 1; k < int'(T_CL) - 1; k++) d_q[k] <= d_q[k-1];
            end

            assign tail_v = v_q[T_CL-2];
            assign tail_d = d_q[T_CL-2];
        end
    endgenerate

    // Read data output; dout holds the last returned word between pulses.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= tail_v;
            if (tail_v) dout_q <= tail_d;
        end
    end

`ifdef DRAM_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of cmd_err pulses.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            err_cnt_q <= '0;
        end else if (err_q && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = 8'h00;
`endif

    assign bus.cmd_ready  = ready_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.cmd_err    = err_q;
    assign bus.bank_busy  = busy_q;
endmodule

// File: tb/tb_dram_timed_bfm.sv
// tb_dram_timed_bfm: self-checking bench for dram_timed_bfm (default parameters).
// Expected read data is pushed into a scoreboard when a legal RD is driven and
// compared, together with its arrival cycle, when dout_valid pulses.
module tb_dram_timed_bfm;
    localparam int unsigned T_CL = 2;

    localparam logic [1:0] ACT = 2'b00;
    localparam logic [1:0] RD  = 2'b01;
    localparam logic [1:0] WR  = 2'b10;
    localparam logic [1:0] PRE = 2'b11;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_b;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_errs = 0;
    exp_t sb_q [$];
    exp_t mon_e;
    logic [7:0] model_mem [int];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dram_timed_bfm_if bus ();

    dram_timed_bfm dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Read-data monitor: every dout_valid must match the scoreboard head, on time.
    always @(posedge clk) begin
        #1;
        if (bus.dout_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_dout_valid", 32'(bus.dout_valid), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("rd_data", 32'(bus.dout), 32'(mon_e.data));
                check("rd_latency", 32'(cyc), 32'(mon_e.due));
            end
        end
    end

    function automatic int mem_key(input int bank, input int row, input int col);
        return (bank * 128 + row) * 8 + col;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one command for one cycle and check its cmd_err response.
    task automatic issue(input logic [1:0] c, input int bank, input int row, input int col,
                         input logic [7:0] d, input logic exp_err);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        bus.bankid    = 3'(bank);
        bus.rowid     = 7'(row);
        bus.colid     = 3'(col);
        bus.din       = d;
        if (!exp_err) begin
            if (c == WR) model_mem[mem_key(bank, row, col)] = d;
            if (c == RD) sb_q.push_back('{data: model_mem[mem_key(bank, row, col)],
                                          due: cyc + int'(T_CL)});
        end
        if (exp_err) exp_errs++;
        @(posedge clk);
        #1;
        check($sformatf("cmd_err c%0d b%0d r%0d", c, bank, row), 32'(bus.cmd_err), 32'(exp_err));
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
        check("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
        check("rst_bank_busy", 32'(bus.bank_busy), 32'd0);
        check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        sb_q.delete();
        exp_errs = 0;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        step();
        check("ready_after_reset", 32'(bus.cmd_ready), 32'd1);
    endtask

    task automatic check_err_cnt();
        int exp_cnt;
`ifdef DRAM_ERR_CNT_EN
        exp_cnt = (exp_errs > 255) ? 255 : exp_errs;
`else
        exp_cnt = 0;
`endif
        check("err_cnt", 32'(bus.err_cnt), 32'(exp_cnt));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_b         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'b00;
        bus.bankid    = '0;
        bus.rowid     = '0;
        bus.colid     = '0;
        bus.din       = '0;
        do_reset();

        // ACT, WR at tRCD, RD right after the WR to the same address
        issue(ACT, 0, 5, 0, 8'h00, 1'b0);
        step();
        step();
        issue(WR, 0, 5, 3, 8'hA5, 1'b0);
        issue(RD, 0, 5, 3, 8'h00, 1'b0);
        repeat (3) step();

        // RD before tRCD is illegal; bank stays busy for T_RCD cycles
        issue(ACT, 1, 7, 0, 8'h00, 1'b0);
        check("busy1_c1", 32'(bus.bank_busy[1]), 32'd1);
        issue(RD, 1, 7, 0, 8'h00, 1'b1);
        check("busy1_c2", 32'(bus.bank_busy[1]), 32'd1);
        step();
        check("busy1_c3", 32'(bus.bank_busy[1]), 32'd1);
        step();
        check("busy1_c4", 32'(bus.bank_busy[1]), 32'd0);

        // Row-mismatch WR leaves the array untouched
        issue(ACT, 2, 9, 0, 8'h00, 1'b0);
        step();
        step();
        issue(WR, 2, 9, 1, 8'h3C, 1'b0);
        issue(WR, 2, 10, 1, 8'hFF, 1'b1);
        issue(RD, 2, 9, 1, 8'h00, 1'b0);
        repeat (3) step();

        // Precharge timing, PRE to idle bank, PRE during activation
        issue(PRE, 0, 0, 0, 8'h00, 1'b0);
        issue(ACT, 0, 6, 0, 8'h00, 1'b1);
        issue(ACT, 0, 6, 0, 8'h00, 1'b0);
        check("busy0_a1", 32'(bus.bank_busy[0]), 32'd1);
        step();
        check("busy0_a2", 32'(bus.bank_busy[0]), 32'd1);
        step();
        check("busy0_a3", 32'(bus.bank_busy[0]), 32'd1);
        step();
        check("busy0_a4", 32'(bus.bank_busy[0]), 32'd0);
        issue(PRE, 3, 0, 0, 8'h00, 1'b0);
        issue(ACT, 4, 1, 0, 8'h00, 1'b0);
        issue(PRE, 4, 0, 0, 8'h00, 1'b1);

        // Reset with a read in flight: no dout_valid afterwards
        issue(RD, 2, 9, 1, 8'h00, 1'b0);
        do_reset();
        repeat (4) step();

        // Interleaved activates, writes, then back-to-back reads
        for (int i = 0; i < 8; i++) issue(ACT, i, 20 + i, 0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) issue(WR, i, 20 + i, i, 8'(8'h30 + 8'(i * 7)), 1'b0);
        for (int i = 0; i < 8; i++) issue(RD, i, 20 + i, i, 8'h00, 1'b0);
        repeat (4) step();
        check_err_cnt();

`ifdef DRAM_ERR_CNT_EN
        // Saturation, then reset mid-stream clears the counter
        for (int i = 0; i < 300; i++) issue(RD, 5, 0, 0, 8'h00, 1'b1);
        step();
        step();
        check_err_cnt();
        issue(RD, 5, 0, 0, 8'h00, 1'b1);
        issue(RD, 5, 0, 0, 8'h00, 1'b1);
        do_reset();
`else
        for (int i = 0; i < 3; i++) issue(RD, 5, 0, 0, 8'h00, 1'b1);
        step();
        step();
        check_err_cnt();
`endif

        repeat (2) step();
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
